// File: rtl/mac_tx_arbiter.sv
// Frame-level IP/ARP arbiter in front of the 10G MAC TX stream input.
// A source keeps its grant until its tlast beat is taken; output is one register stage.
module mac_tx_arbiter #(
  parameter int P_PRIORITY_MODE = 0,
  parameter int P_CNT_WIDTH     = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [63:0]            s_axis_ip_data,
  input  logic [79:0]            s_axis_ip_user,
  input  logic [7:0]             s_axis_ip_keep,
  input  logic                   s_axis_ip_last,
  input  logic                   s_axis_ip_valid,
  output logic                   s_axis_ip_ready,
  input  logic [63:0]            s_axis_arp_data,
  input  logic [79:0]            s_axis_arp_user,
  input  logic [7:0]             s_axis_arp_keep,
  input  logic                   s_axis_arp_last,
  input  logic                   s_axis_arp_valid,
  output logic                   s_axis_arp_ready,
  output logic [63:0]            m_axis_mac_data,
  output logic [79:0]            m_axis_mac_user,
  output logic [7:0]             m_axis_mac_keep,
  output logic                   m_axis_mac_last,
  output logic                   m_axis_mac_valid,
  input  logic                   m_axis_mac_ready,
  output logic [1:0]             o_active_src,
  output logic [P_CNT_WIDTH-1:0] o_ip_frame_cnt,
  output logic [P_CNT_WIDTH-1:0] o_arp_frame_cnt
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_IP   = 2'b01;
  localparam logic [1:0] S_ARP  = 2'b10;

  logic [1:0]             r_state;
  logic                   r_last_arp;
  logic [63:0]            r_data;
  logic [79:0]            r_user;
  logic [7:0]             r_keep;
  logic                   r_last;
  logic                   r_valid;
  logic [P_CNT_WIDTH-1:0] r_ip_cnt;
  logic [P_CNT_WIDTH-1:0] r_arp_cnt;

  logic       w_free;
  logic       w_ld_ip;
  logic       w_ld_arp;
  logic       w_ld;
  logic [1:0] w_grant;

  assign w_free = !r_valid | m_axis_mac_ready;

  assign s_axis_ip_ready  = (r_state == S_IP) & w_free;
  assign s_axis_arp_ready = (r_state == S_ARP) & w_free;

  assign w_ld_ip  = s_axis_ip_valid & s_axis_ip_ready;
  assign w_ld_arp = s_axis_arp_valid & s_axis_arp_ready;
  assign w_ld     = w_ld_ip | w_ld_arp;

  // Tie goes to ARP in fixed mode, else to whoever was not served last
  always_comb begin
    w_grant = S_IDLE;
    unique case (1'b1)
      s_axis_ip_valid & s_axis_arp_valid:
        w_grant = (P_PRIORITY_MODE == 1 || !r_last_arp) ?
                  S_ARP : S_IP;
      s_axis_ip_valid & !s_axis_arp_valid:
        w_grant = S_IP;
      !s_axis_ip_valid & s_axis_arp_valid:
        w_grant = S_ARP;
      default:
        w_grant = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= S_IDLE;
      r_last_arp <= 1'b1;
      r_data     <= '0;
      r_user     <= '0;
      r_keep     <= '0;
      r_last     <= 1'b0;
      r_valid    <= 1'b0;
      r_ip_cnt   <= '0;
      r_arp_cnt  <= '0;
    end else begin
      if (w_ld) begin
        r_data  <= w_ld_arp ? s_axis_arp_data : s_axis_ip_data;
        r_user  <= w_ld_arp ? s_axis_arp_user : s_axis_ip_user;
        r_keep  <= w_ld_arp ? s_axis_arp_keep : s_axis_ip_keep;
        r_last  <= w_ld_arp ? s_axis_arp_last : s_axis_ip_last;
        r_valid <= 1'b1;
      end else if (m_axis_mac_ready) begin
        r_valid <= 1'b0;
      end

      unique case (r_state)
        S_IDLE: r_state <= w_grant;
        S_IP: begin
          if (w_ld_ip & s_axis_ip_last) begin
            r_state    <= S_IDLE;
            r_last_arp <= 1'b0;
            r_ip_cnt   <= r_ip_cnt + P_CNT_WIDTH'(1);
          end
        end
        S_ARP: begin
          if (w_ld_arp & s_axis_arp_last) begin
            r_state    <= S_IDLE;
            r_last_arp <= 1'b1;
            r_arp_cnt  <= r_arp_cnt + P_CNT_WIDTH'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m_axis_mac_data  = r_data;
  assign m_axis_mac_user  = r_user;
  assign m_axis_mac_keep  = r_keep;
  assign m_axis_mac_last  = r_last;
  assign m_axis_mac_valid = r_valid;
  assign o_active_src     = r_state;
  assign o_ip_frame_cnt   = r_ip_cnt;
  assign o_arp_frame_cnt  = r_arp_cnt;

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Directed bench for mac_tx_arbiter; instance 0 is round-robin, instance 1 ARP-priority.
// Beats carry tag/source/index so order, loss and duplication are visible.
module tb_mac_tx_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [152:0] ip_bt  [2];
  logic [152:0] arp_bt [2];
  logic         ip_v   [2];
  logic         arp_v  [2];
  logic         m_rdy  [2];
  wire          ip_r   [2];
  wire          arp_r  [2];
  wire  [63:0]  m_data [2];
  wire  [79:0]  m_user [2];
  wire  [7:0]   m_keep [2];
  wire          m_last [2];
  wire          m_valid[2];
  wire  [1:0]   act    [2];
  wire  [15:0]  ipc    [2];
  wire  [15:0]  arpc   [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mac_tx_arbiter #(
      .P_PRIORITY_MODE(g),
      .P_CNT_WIDTH    (16)
    ) u_dut (
      .i_clk           (clk),
      .i_rst           (rst_n),
      .s_axis_ip_data  (ip_bt[g][152:89]),
      .s_axis_ip_user  (ip_bt[g][88:9]),
      .s_axis_ip_keep  (ip_bt[g][8:1]),
      .s_axis_ip_last  (ip_bt[g][0]),
      .s_axis_ip_valid (ip_v[g]),
      .s_axis_ip_ready (ip_r[g]),
      .s_axis_arp_data (arp_bt[g][152:89]),
      .s_axis_arp_user (arp_bt[g][88:9]),
      .s_axis_arp_keep (arp_bt[g][8:1]),
      .s_axis_arp_last (arp_bt[g][0]),
      .s_axis_arp_valid(arp_v[g]),
      .s_axis_arp_ready(arp_r[g]),
      .m_axis_mac_data (m_data[g]),
      .m_axis_mac_user (m_user[g]),
      .m_axis_mac_keep (m_keep[g]),
      .m_axis_mac_last (m_last[g]),
      .m_axis_mac_valid(m_valid[g]),
      .m_axis_mac_ready(m_rdy[g]),
      .o_active_src    (act[g]),
      .o_ip_frame_cnt  (ipc[g]),
      .o_arp_frame_cnt (arpc[g])
    );
  end

  int           s_len [2][2];
  int           s_idx [2][2];
  int           s_nfr [2][2];
  bit           s_act [2][2];
  logic [7:0]   s_tag [2][2];
  logic [7:0]   s_lk  [2][2];
  bit           hs    [2][2];
  int           rmode [2];
  bit           stall [2];
  logic [152:0] prevb [2];
  int           badr  [2];
  logic [152:0] outq  [2][$];
  int           outc  [2][$];
  int           cyc;
  int           checks = 0;
  int           fails  = 0;

  task automatic chk(string t, logic [152:0] got, logic [152:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", t, got, exp);
    end
  endtask

  function automatic logic [152:0] mk(int s, logic [7:0] tg, int ln,
                                      int ix, logic [7:0] lkp);
    logic lst;
    lst = (ix == ln - 1);
    return {tg, 8'(s), 16'(ix), 32'hC0DE_0000 | 32'(ix),
            16'(ln * 8), 40'h02_0000_0000, tg,
            (s == 1) ? 16'h0806 : 16'h0800,
            lst ? lkp : 8'hFF, lst};
  endfunction

  function automatic logic [152:0] outv(int k);
    return {m_data[k], m_user[k], m_keep[k], m_last[k]};
  endfunction

  task automatic drive();
    for (int k = 0; k < 2; k++) begin
      ip_bt[k]  = mk(0, s_tag[k][0], s_len[k][0], s_idx[k][0], s_lk[k][0]);
      arp_bt[k] = mk(1, s_tag[k][1], s_len[k][1], s_idx[k][1], s_lk[k][1]);
      ip_v[k]   = s_act[k][0];
      arp_v[k]  = s_act[k][1];
    end
  endtask

  task automatic start(int k, int s, logic [7:0] tg, int ln,
                       logic [7:0] l, int more);
    s_tag[k][s] = tg;
    s_len[k][s] = ln;
    s_lk[k][s]  = l;
    s_idx[k][s] = 0;
    s_nfr[k][s] = more;
    s_act[k][s] = 1'b1;
    drive();
  endtask

  // Sample at negedge, advance sources just after posedge
  task automatic step();
    logic [152:0] cur;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      cur = outv(k);
      if (stall[k]) chk("hold", cur, prevb[k]);
      stall[k] = m_valid[k] & !m_rdy[k];
      prevb[k] = cur;
      if (m_valid[k] && m_rdy[k]) begin
        outq[k].push_back(cur);
        outc[k].push_back(cyc);
      end
      hs[k][0] = ip_v[k] & ip_r[k];
      hs[k][1] = arp_v[k] & arp_r[k];
      if ((ip_r[k] && act[k] != 2'b01) ||
          (arp_r[k] && act[k] != 2'b10))
        badr[k]++;
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 2; s++) begin
        if (hs[k][s]) begin
          if (s_idx[k][s] == s_len[k][s] - 1) begin
            if (s_nfr[k][s] > 0) begin
              s_nfr[k][s]--;
              s_tag[k][s]++;
              s_idx[k][s] = 0;
            end else begin
              s_act[k][s] = 1'b0;
            end
          end else begin
            s_idx[k][s]++;
          end
        end
      end
      if (rmode[k] == 1) m_rdy[k] = !m_rdy[k];
    end
    drive();
  endtask

  task automatic clr_src();
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 2; s++) begin
        s_act[k][s] = 1'b0;
        s_nfr[k][s] = 0;
        s_idx[k][s] = 0;
        s_len[k][s] = 1;
        s_tag[k][s] = 8'h0;
        s_lk[k][s]  = 8'hFF;
      end
      m_rdy[k] = 1'b1;
      rmode[k] = 0;
      stall[k] = 1'b0;
      badr[k]  = 0;
      outq[k].delete();
      outc[k].delete();
    end
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr_src();
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic run_until(int k, int n, int budget);
    int i;
    i = 0;
    while (outq[k].size() < n && i < budget) begin
      step();
      i++;
    end
    chk("beats_out", outq[k].size(), n);
  endtask

  task automatic exp_frame(int k, int s, logic [7:0] tg, int ln,
                           logic [7:0] l, inout int pos);
    for (int i = 0; i < ln; i++) begin
      if (pos < outq[k].size())
        chk("beat", outq[k][pos], mk(s, tg, ln, i, l));
      else
        chk("beat_missing", '0, mk(s, tg, ln, i, l));
      pos++;
    end
  endtask

  initial begin
    int pos;
    cyc = 0;

    // Reset state and IP-only frame with partial last beat
    do_reset();
    chk("rst_out", outv(0), '0);
    chk("rst_mvalid", m_valid[0], 0);
    chk("rst_rdy", {ip_r[0], arp_r[0]}, 0);
    chk("rst_cnt", {ipc[0], arpc[0]}, 0);
    start(0, 0, 8'h11, 10, 8'hFE, 0);
    chk("t1_act_n", act[0], 2'b00);
    chk("t1_rdy_n", ip_r[0], 0);
    step();
    chk("t1_act_n1", act[0], 2'b01);
    chk("t1_rdy_n1", ip_r[0], 1);
    chk("t1_mv_n1", m_valid[0], 0);
    step();
    chk("t1_mv_n2", m_valid[0], 1);
    chk("t1_b0_n2", outv(0), mk(0, 8'h11, 10, 0, 8'hFE));
    run_until(0, 10, 40);
    pos = 0;
    exp_frame(0, 0, 8'h11, 10, 8'hFE, pos);
    if (outc[0].size() >= 10)
      chk("t1_tput", outc[0][9] - outc[0][0], 9);
    chk("t1_ipc", ipc[0], 1);
    chk("t1_arpc", arpc[0], 0);
    chk("t1_act_end", act[0], 2'b00);

    // Simultaneous requests: round-robin vs ARP priority
    do_reset();
    for (int k = 0; k < 2; k++) begin
      start(k, 0, 8'h21, 6, 8'h0F, 0);
      start(k, 1, 8'h31, 4, 8'h03, 0);
    end
    run_until(0, 10, 60);
    run_until(1, 10, 60);
    pos = 0;
    exp_frame(0, 0, 8'h21, 6, 8'h0F, pos);
    exp_frame(0, 1, 8'h31, 4, 8'h03, pos);
    pos = 0;
    exp_frame(1, 1, 8'h31, 4, 8'h03, pos);
    exp_frame(1, 0, 8'h21, 6, 8'h0F, pos);
    if (outc[0].size() >= 10)
      chk("t2_gap", outc[0][6] - outc[0][5], 2);
    if (outc[1].size() >= 10)
      chk("t3_gap", outc[1][4] - outc[1][3], 2);
    chk("t2_excl", badr[0], 0);
    chk("t3_excl", badr[1], 0);
    chk("t2_cnt", {ipc[0], arpc[0]}, {16'd1, 16'd1});
    chk("t3_cnt", {ipc[1], arpc[1]}, {16'd1, 16'd1});

    // Output back-pressure toggling every cycle
    do_reset();
    rmode[0] = 1;
    start(0, 0, 8'h41, 10, 8'h80, 0);
    run_until(0, 10, 60);
    pos = 0;
    exp_frame(0, 0, 8'h41, 10, 8'h80, pos);
    chk("t4_ipc", ipc[0], 1);
    chk("t4_excl", badr[0], 0);

    // Continuous requests from both sources alternate
    do_reset();
    start(0, 0, 8'h50, 3, 8'h07, 2);
    start(0, 1, 8'h60, 2, 8'h01, 2);
    run_until(0, 15, 100);
    pos = 0;
    for (int f = 0; f < 3; f++) begin
      exp_frame(0, 0, 8'h50 + 8'(f), 3, 8'h07, pos);
      exp_frame(0, 1, 8'h60 + 8'(f), 2, 8'h01, pos);
    end
    chk("t5_cnt", {ipc[0], arpc[0]}, {16'd3, 16'd3});
    chk("t5_excl", badr[0], 0);

    // Asynchronous reset mid-frame, then a clean ARP frame
    do_reset();
    start(0, 0, 8'h70, 10, 8'hFF, 0);
    run_until(0, 5, 30);
    chk("t6_pre_mv", m_valid[0], 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_out", outv(0), '0);
    chk("t6_rst_mv", m_valid[0], 0);
    chk("t6_rst_act", act[0], 2'b00);
    chk("t6_rst_rdy", {ip_r[0], arp_r[0]}, 0);
    clr_src();
    step();
    rst_n = 1'b1;
    step();
    start(0, 1, 8'h81, 5, 8'h3F, 0);
    run_until(0, 5, 30);
    pos = 0;
    exp_frame(0, 1, 8'h81, 5, 8'h3F, pos);
    chk("t6_cnt", {ipc[0], arpc[0]}, {16'd0, 16'd1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
